// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the parametrised direct-mapped read-only cache:
// FSM state encoding, address-field extraction and saturating counters.
package dm_cache_pkg;

  // Widest address or counter the helpers below can handle.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_DATA,
    S_RESPOND
  } state_e;

  function automatic logic [MAX_W-1:0] low_mask(input int unsigned width);
    return (MAX_W'(1) << width) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] addr_word(input logic [MAX_W-1:0] addr,
                                                 input int unsigned   byte_w,
                                                 input int unsigned   offset_w);
    return (addr >> byte_w) & low_mask(offset_w);
  endfunction

  function automatic logic [MAX_W-1:0] addr_index(input logic [MAX_W-1:0] addr,
                                                  input int unsigned   byte_w,
                                                  input int unsigned   offset_w,
                                                  input int unsigned   index_w);
    return (addr >> (byte_w + offset_w)) & low_mask(index_w);
  endfunction

  function automatic logic [MAX_W-1:0] addr_tag(input logic [MAX_W-1:0] addr,
                                                input int unsigned   byte_w,
                                                input int unsigned   offset_w,
                                                input int unsigned   index_w);
    return addr >> (byte_w + offset_w + index_w);
  endfunction

  // Increment that sticks at all-ones for a counter of the given width.
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] value,
                                               input int unsigned   width);
    logic [MAX_W-1:0] mask;
    mask = low_mask(width);
    return ((value & mask) == mask) ? value : value + MAX_W'(1);
  endfunction

endpackage

// File: rtl/dm_cache_param_if.sv
// Core-side request/response bus and memory-side line-refill bus of the cache.
// In both interfaces "master" is the side that issues requests.
interface dm_cache_core_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_data;
  logic              resp_hit;

  modport master (
    output req_valid, req_addr, flush,
    input  req_ready, resp_valid, resp_data, resp_hit
  );

  modport slave (
    input  req_valid, req_addr, flush,
    output req_ready, resp_valid, resp_data, resp_hit
  );
endinterface

interface dm_cache_mem_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dm_cache_store.sv
// Tag array, data array and per-line valid bits of the cache. One write port
// shared by refill beats and tag updates, combinational read, bulk flush.
module dm_cache_store #(
  parameter int WORD_W   = 32,
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                inval_i,
  input  logic                tag_we_i,
  input  logic                data_we_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [OFFSET_W-1:0] wr_word_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_word_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [WORD_W-1:0]   rd_data_o
);
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES*WORDS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= '0;
    end else if (inval_i) begin
      valid_q[wr_index_i] <= 1'b0;
    end else if (tag_we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents are meaningful, so the arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
    if (data_we_i) begin
      data_q[{wr_index_i, wr_word_i}] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[{rd_index_i, rd_word_i}];

endmodule

// File: rtl/dm_cache_param.sv
// Parametrised read-only direct-mapped cache: request FSM, burst line refill
// from main memory, flush and saturating access/miss statistics.
module dm_cache_param
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  dm_cache_core_if.slave     core,
  dm_cache_mem_if.master     mem,
  output logic [CNT_W-1:0]   access_count,
  output logic [CNT_W-1:0]   miss_count
);
  localparam int unsigned BYTE_W   = $clog2(WORD_W / 8);
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W - BYTE_W;
  localparam int unsigned LINE_LSB = OFFSET_W + BYTE_W;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] word_q, word_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [WORD_W-1:0]   fill_word_q, fill_word_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [WORD_W-1:0]   resp_data_q, resp_data_d;
  logic [CNT_W-1:0]    access_q, access_d;
  logic [CNT_W-1:0]    miss_q, miss_d;

  logic                st_flush, st_inval, st_tag_we, st_data_we;
  logic                st_rd_valid;
  logic [TAG_W-1:0]    st_rd_tag;
  logic [WORD_W-1:0]   st_rd_data;
  logic [MAX_W-1:0]    req_addr_ext;
  logic                accept, hit;

  assign req_addr_ext   = MAX_W'(core.req_addr);
  assign core.req_ready = (state_q == S_IDLE) && !core.flush && !rst;
  assign accept         = core.req_valid && core.req_ready;
  assign hit            = st_rd_valid && (st_rd_tag == tag_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    tag_d        = tag_q;
    index_d      = index_q;
    word_d       = word_q;
    beat_d       = beat_q;
    fill_word_d  = fill_word_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_data_d  = resp_data_q;
    access_d     = access_q;
    miss_d       = miss_q;
    st_flush     = 1'b0;
    st_inval     = 1'b0;
    st_tag_we    = 1'b0;
    st_data_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (core.flush) begin
          st_flush = 1'b1;
        end else if (accept) begin
          tag_d    = TAG_W'(addr_tag(req_addr_ext, BYTE_W, OFFSET_W, INDEX_W));
          index_d  = INDEX_W'(addr_index(req_addr_ext, BYTE_W, OFFSET_W, INDEX_W));
          word_d   = OFFSET_W'(addr_word(req_addr_ext, BYTE_W, OFFSET_W));
          access_d = CNT_W'(sat_inc(MAX_W'(access_q), CNT_W));
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_data_d  = st_rd_data;
          state_d      = S_IDLE;
        end else begin
          // Invalidate now so an abandoned refill can never produce a hit.
          miss_d   = CNT_W'(sat_inc(MAX_W'(miss_q), CNT_W));
          st_inval = 1'b1;
          state_d  = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        if (mem.mem_req_ready) begin
          beat_d  = '0;
          state_d = S_REFILL_DATA;
        end
      end
      S_REFILL_DATA: begin
        if (mem.mem_rvalid) begin
          st_data_we = 1'b1;
          beat_d     = beat_q + 1'b1;
          if (beat_q == word_q) begin
            fill_word_d = mem.mem_rdata;
          end
          if (&beat_q) begin
            state_d = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        st_tag_we    = 1'b1;
        resp_valid_d = 1'b1;
        resp_data_d  = fill_word_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      access_q     <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_data_q  <= resp_data_d;
      access_q     <= access_d;
      miss_q       <= miss_d;
    end
  end

  // Request fields and refill progress are only read in states entered after
  // they have been loaded, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q       <= tag_d;
    index_q     <= index_d;
    word_q      <= word_d;
    beat_q      <= beat_d;
    fill_word_q <= fill_word_d;
  end

  dm_cache_store #(
    .WORD_W   (WORD_W),
    .TAG_W    (TAG_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (st_flush),
    .inval_i    (st_inval),
    .tag_we_i   (st_tag_we),
    .data_we_i  (st_data_we),
    .wr_index_i (index_q),
    .wr_word_i  (beat_q),
    .wr_tag_i   (tag_q),
    .wr_data_i  (mem.mem_rdata),
    .rd_index_i (index_q),
    .rd_word_i  (word_q),
    .rd_valid_o (st_rd_valid),
    .rd_tag_o   (st_rd_tag),
    .rd_data_o  (st_rd_data)
  );

  assign mem.mem_req_valid = (state_q == S_REFILL_REQ);
  assign mem.mem_req_addr  = mem.mem_req_valid
                           ? (ADDR_W'({tag_q, index_q}) << LINE_LSB) : '0;

  assign core.resp_valid = resp_valid_q;
  assign core.resp_hit   = resp_hit_q;
  assign core.resp_data  = resp_data_q;
  assign access_count    = access_q;
  assign miss_count      = miss_q;

endmodule

// File: tb/tb_dm_cache_param.sv
// Bench for dm_cache_param: memory model returns each word's byte address,
// responses are matched against a queue of expected {data, hit} entries.
module tb_dm_cache_param;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;   // narrow so saturation is reachable quickly

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] access_count, miss_count;

  dm_cache_core_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) core_if ();
  dm_cache_mem_if  #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) mem_if ();

  dm_cache_param #(
    .ADDR_W   (ADDR_W),
    .WORD_W   (WORD_W),
    .INDEX_W  (8),
    .OFFSET_W (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (core_if),
    .mem          (mem_if),
    .access_count (access_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic              hit;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_accept_cyc = 0;
  int          resp_seen = 0;

  // Memory model controls and observations.
  int                ready_delay = 2;
  int                gap = 0;
  int                abort_beat = -1;
  int                stray_left = 0;
  int                mem_reqs = 0;
  int                last_beats = 0;
  logic [ADDR_W-1:0] last_line = '0;
  bit                mem_aborted = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && core_if.resp_valid === 1'b1) begin
      exp_t e;
      resp_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got data=%h hit=%b, required no response",
                 core_if.resp_data, core_if.resp_hit);
      end else begin
        e = sb.pop_front();
        if (core_if.resp_data !== e.data || core_if.resp_hit !== e.hit) begin
          errors++;
          $display("FAIL resp: got data=%h hit=%b, required data=%h hit=%b",
                   core_if.resp_data, core_if.resp_hit, e.data, e.hit);
        end
        if (e.hit) begin
          checks++;
          if (cyc - last_accept_cyc !== 1) begin
            errors++;
            $display("FAIL hit_latency: got %0d cycles, required 1",
                     cyc - last_accept_cyc);
          end
        end
      end
    end
  end

  // Main-memory model: mem_req_ready after ready_delay cycles, then 16 beats.
  initial begin : mem_model
    logic [ADDR_W-1:0] line;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rvalid    = 1'b0;
    mem_if.mem_rdata     = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_rvalid = 1'b0;
      if (stray_left > 0) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hDEAD_BEEF;
        stray_left--;
      end else if (!rst && mem_if.mem_req_valid === 1'b1) begin
        line       = mem_if.mem_req_addr;
        last_line  = line;
        last_beats = 0;
        mem_reqs++;
        for (int d = 0; d < ready_delay; d++) begin
          @(negedge clk);
          checks++;
          if (mem_if.mem_req_valid !== 1'b1 || mem_if.mem_req_addr !== line) begin
            errors++;
            $display("FAIL mem_req_stable: got valid=%b addr=%h, required valid=1 addr=%h",
                     mem_if.mem_req_valid, mem_if.mem_req_addr, line);
          end
        end
        mem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0;
        checks++;
        if (mem_if.mem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL mem_req_drop: got valid=%b, required 0", mem_if.mem_req_valid);
        end
        for (int b = 0; b < 16; b++) begin
          mem_if.mem_rvalid = 1'b1;
          mem_if.mem_rdata  = line + 32'(4 * b);
          @(negedge clk);
          mem_if.mem_rvalid = 1'b0;
          last_beats++;
          if (b == abort_beat) begin
            mem_aborted = 1'b1;
            break;
          end
          repeat (gap) @(negedge clk);
        end
      end
    end
  end

  task automatic issue_read(input logic [ADDR_W-1:0] addr,
                            input logic [WORD_W-1:0] exp_data,
                            input logic              exp_hit);
    int waited = 0;
    @(negedge clk);
    sb.push_back('{data: exp_data, hit: exp_hit});
    core_if.req_valid = 1'b1;
    core_if.req_addr  = addr;
    while (core_if.req_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (core_if.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: addr=%h got req_ready=%b, required 1",
               addr, core_if.req_ready);
      void'(sb.pop_back());
      core_if.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    last_accept_cyc   = cyc;
    core_if.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string what);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_resp_timeout: got %0d pending, required 0", what, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_if.req_valid = 1'b0;
    core_if.req_addr  = '0;
    core_if.flush     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (core_if.resp_valid !== 1'b0 || core_if.resp_hit !== 1'b0 || core_if.resp_data !== '0) begin
      errors++;
      $display("FAIL reset_resp: got valid=%b hit=%b data=%h, required all 0",
               core_if.resp_valid, core_if.resp_hit, core_if.resp_data);
    end
    checks++;
    if (mem_if.mem_req_valid !== 1'b0 || mem_if.mem_req_addr !== '0) begin
      errors++;
      $display("FAIL reset_mem_req: got valid=%b addr=%h, required 0",
               mem_if.mem_req_valid, mem_if.mem_req_addr);
    end
    checks++;
    if (access_count !== '0 || miss_count !== '0 || core_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: got access=%0d miss=%0d ready=%b, required 0 0 0",
               access_count, miss_count, core_if.req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (core_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", core_if.req_ready);
    end
  endtask

  task automatic test_cold_miss();
    issue_read(32'h0000_1044, 32'h0000_1044, 1'b0);
    wait_drain("cold_miss");
    checks++;
    if (last_line !== 32'h0000_1040 || mem_reqs !== 1 || last_beats !== 16) begin
      errors++;
      $display("FAIL cold_miss_refill: got addr=%h reqs=%0d beats=%0d, required 00001040 1 16",
               last_line, mem_reqs, last_beats);
    end
    checks++;
    if (access_count !== CNT_W'(1) || miss_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL cold_miss_counts: got access=%0d miss=%0d, required 1 1",
               access_count, miss_count);
    end
  endtask

  task automatic test_hit();
    int reqs0 = mem_reqs;
    issue_read(32'h0000_1048, 32'h0000_1048, 1'b1);
    wait_drain("hit");
    checks++;
    if (mem_reqs !== reqs0 || access_count !== CNT_W'(2) || miss_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL hit_side_effects: got reqs=%0d access=%0d miss=%0d, required %0d 2 1",
               mem_reqs, access_count, miss_count, reqs0);
    end
  endtask

  task automatic test_conflict();
    issue_read(32'h0000_5044, 32'h0000_5044, 1'b0);
    wait_drain("conflict_a");
    checks++;
    if (last_line !== 32'h0000_5040) begin
      errors++;
      $display("FAIL conflict_line: got %h, required 00005040", last_line);
    end
    issue_read(32'h0000_1044, 32'h0000_1044, 1'b0);
    wait_drain("conflict_b");
    checks++;
    if (access_count !== CNT_W'(4) || miss_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL conflict_counts: got access=%0d miss=%0d, required 4 3",
               access_count, miss_count);
    end
  endtask

  task automatic test_flush_backpressure();
    @(negedge clk);
    core_if.flush     = 1'b1;
    core_if.req_valid = 1'b1;
    core_if.req_addr  = 32'h0000_1044;
    #1;
    checks++;
    if (core_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b, required 0", core_if.req_ready);
    end
    @(negedge clk);
    core_if.flush     = 1'b0;
    core_if.req_valid = 1'b0;
    checks++;
    if (access_count !== CNT_W'(4)) begin
      errors++;
      $display("FAIL flush_priority: got access=%0d, required 4", access_count);
    end
    ready_delay = 10;
    issue_read(32'h0000_5044, 32'h0000_5044, 1'b0);
    wait_drain("backpressure");
    ready_delay = 2;
    issue_read(32'h0000_5048, 32'h0000_5048, 1'b1);
    wait_drain("post_fill_hit");
    @(negedge clk);
    core_if.flush = 1'b1;
    @(negedge clk);
    core_if.flush = 1'b0;
    issue_read(32'h0000_5044, 32'h0000_5044, 1'b0);
    wait_drain("post_flush");
    checks++;
    if (access_count !== CNT_W'(7) || miss_count !== CNT_W'(5)) begin
      errors++;
      $display("FAIL flush_counts: got access=%0d miss=%0d, required 7 5",
               access_count, miss_count);
    end
  endtask

  task automatic test_reset_mid_refill();
    int n = 0;
    int r0, s0;
    gap         = 1;
    abort_beat  = 5;
    mem_aborted = 1'b0;
    issue_read(32'h0000_1044, 32'h0000_1044, 1'b0);
    while (!mem_aborted && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem_aborted || last_beats !== 6) begin
      errors++;
      $display("FAIL abort_reach: got aborted=%b beats=%0d, required 1 6",
               mem_aborted, last_beats);
    end
    rst = 1'b1;
    sb.delete();
    abort_beat = -1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (core_if.resp_valid !== 1'b0 || core_if.resp_data !== '0 || mem_if.mem_req_valid !== 1'b0 ||
        mem_if.mem_req_addr !== '0 || access_count !== '0 || miss_count !== '0) begin
      errors++;
      $display("FAIL mid_refill_reset: got resp=%b data=%h mreq=%b maddr=%h acc=%0d miss=%0d, required all 0",
               core_if.resp_valid, core_if.resp_data, mem_if.mem_req_valid,
               mem_if.mem_req_addr, access_count, miss_count);
    end
    rst = 1'b0;
    r0 = mem_reqs;
    s0 = resp_seen;
    stray_left = 3;
    repeat (6) @(negedge clk);
    checks++;
    if (mem_reqs !== r0 || resp_seen !== s0 || core_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_rvalid: got reqs=%0d resps=%0d ready=%b, required %0d %0d 1",
               mem_reqs, resp_seen, core_if.req_ready, r0, s0);
    end
    issue_read(32'h0000_1044, 32'h0000_1044, 1'b0);
    wait_drain("refill_after_reset");
    checks++;
    if (mem_reqs !== r0 + 1 || last_beats !== 16 || access_count !== CNT_W'(1) ||
        miss_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL refill_after_reset: got reqs=%0d beats=%0d acc=%0d miss=%0d, required %0d 16 1 1",
               mem_reqs, last_beats, access_count, miss_count, r0 + 1);
    end
    gap = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      logic [ADDR_W-1:0] a;
      a = 32'h0000_1040 + 32'(4 * (i % 16));
      issue_read(a, a, 1'b1);
      if (i == 4) begin
        checks++;
        if (access_count !== CNT_W'(6)) begin
          errors++;
          $display("FAIL pre_saturation: got access=%0d, required 6", access_count);
        end
      end
    end
    wait_drain("saturation");
    checks++;
    if (access_count !== CNT_W'(15) || miss_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL saturation: got access=%0d miss=%0d, required 15 1",
               access_count, miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_backpressure();
    test_reset_mid_refill();
    test_saturation();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_cache_param.md
Name: dm_cache_param

Overview:
Parametrised, read-only, direct-mapped cache with a valid bit per line, valid/ready request handshake, burst line-refill port to main memory, flush, and access/miss statistics counters. It succeeds the fixed 256-line x 16-word, 32-bit-address cache. It sits between a load-issuing core/testbench and the main-memory model. Line, index and word widths are generic, and the memory side tolerates backpressure and gaps between beats.

Parameters:
ADDR_W, 32, byte-address width
WORD_W, 32, data word width; multiple of 8
INDEX_W, 8, log2(number of lines)
OFFSET_W, 4, log2(words per line)
CNT_W, 32, statistics counter width
Derived: BYTE_W = log2(WORD_W/8); TAG_W = ADDR_W-INDEX_W-OFFSET_W-BYTE_W. Defaults give tag 18, index 8, word 4, byte 2.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  read request present
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  ADDR_W  byte address; low BYTE_W bits ignored
flush  in  1  invalidate all lines
resp_valid  out  1  one-cycle response pulse
resp_data  out  WORD_W  requested word, valid with resp_valid
resp_hit  out  1  1 = hit, 0 = served by refill
mem_req_valid  out  1  line-fetch request
mem_req_ready  in  1  memory accepts line address
mem_req_addr  out  ADDR_W  line-aligned address (low OFFSET_W+BYTE_W bits zero)
mem_rvalid  in  1  one refill beat present
mem_rdata  in  WORD_W  refill word; beats arrive in ascending word order
access_count  out  CNT_W  accepted requests, saturating
miss_count  out  CNT_W  misses, saturating

Behaviour:
- Reset values: all outputs 0, all valid bits 0, state IDLE, counters 0. Tag and data arrays are not reset.
- req_ready = (state==IDLE) && !flush && !rst.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND.
- IDLE:
  - flush=1 clears every valid bit at the next edge and stays in IDLE. Flush has priority over a request in the same cycle.
  - flush is ignored outside IDLE; the source must hold it until req_ready would be high.
  - On a request handshake: latch tag, index and word; access_count+1; go to LOOKUP.
- LOOKUP: hit = valid[index] && tag_array[index]==tag.
  - Hit: resp_valid=1, resp_hit=1, resp_data=data[index][word] at the next edge; go to IDLE. Hit latency is 1 cycle after acceptance, giving 1 request per 2 cycles.
  - Miss: miss_count+1; valid[index] cleared; go to REFILL_REQ with mem_req_valid=1.
- REFILL_REQ: hold mem_req_valid and a stable mem_req_addr until mem_req_ready. On the handshake, drop mem_req_valid, clear the beat counter, go to REFILL_DATA.
- REFILL_DATA:
  - Each mem_rvalid writes mem_rdata to data[index][beat] and increments the beat counter (OFFSET_W bits).
  - The beat whose number equals the latched word is captured as the response word.
  - Cycles without mem_rvalid insert gaps and have no other effect.
  - On beat 2^OFFSET_W-1, go to RESPOND.
- RESPOND: write the tag, set valid[index]; resp_valid=1, resp_hit=0 at the next edge with the captured word; go to IDLE. Miss latency = 1 + request-handshake wait + beat cycles + 1.
- mem_rvalid outside REFILL_DATA is ignored.
- Reset mid-refill abandons the fill. The line stays invalid and no partial hits are possible.
- Counters saturate at all-ones and never wrap. A request that is a miss increments both counters.
- resp_valid is never back-pressured; it is high for exactly one cycle per accepted request.

Decomposition:
- Shared package dm_cache_pkg holds:
  - the FSM state enum;
  - address-field extraction functions (tag/index/word of an address), parametrised by widths;
  - a saturating-increment function.
- One sub-module, dm_cache_store: tag array, data array and valid vector. It has a single write port, a combinational read and a flush-clear input. The top level holds the FSM, counters and both handshakes.

Test Plan (defaults; memory model returns data = word's byte address, 2-cycle mem_req_ready delay):
1. Cold miss: after reset, read 0x00001044 -> mem_req_addr=0x00001040, 16 beats; resp_data=0x00001044, resp_hit=0; access_count=1, miss_count=1.
2. Hit: then read 0x00001048 -> resp_valid exactly 1 cycle after acceptance; resp_data=0x00001048, resp_hit=1; no mem_req_valid; miss_count stays 1.
3. Conflict: read 0x00005044 (same index 0x41, tag 1) -> miss, line refilled, data 0x00005044; re-read 0x00001044 -> miss again; miss_count=3.
4. Flush and backpressure:
   - Assert flush together with req_valid -> req_ready=0 that cycle.
   - Then read 0x00005044 -> miss.
   - Hold mem_req_ready low 10 cycles -> mem_req_valid and address stable throughout.
5. Gappy beats and reset mid-refill:
   - Beats with 1-cycle gaps, rst after beat 5 -> outputs and counters 0.
   - Stray mem_rvalid is ignored.
   - Read 0x00001044 -> miss with a full refill.
6. Saturation: with CNT_W=4, issue 20 hits -> access_count=15 and holds at 15.
